// File: rtl/uart_boot_loader_if.sv
// UART CPU-port and memory write-port signals used by the boot loader.
//
// Handshakes:
//   UART   : a byte is present while uart_si[31:8] == 0. The consumer raises
//            uart_re, holds it until uart_si returns to 32'hFFFF_FFFF, then
//            drops it on the following clock.
//   Memory : mem_we is valid, mem_ready is ready. A word transfers on a clock
//            edge where both are high. While mem_we is high and mem_ready is
//            low, mem_addr and mem_wdata are held stable.
interface uart_boot_loader_if;
    logic [31:0] uart_si;
    logic        uart_re;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_ready;

    modport master (
        input  uart_si,
        output uart_re,
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_ready
    );

    modport slave (
        output uart_si,
        input  uart_re,
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_ready
    );
endinterface

// File: rtl/uart_boot_loader.sv
// Boot loader: pulls a framed image out of the UART receive register,
// assembles little-endian words, writes them to memory and validates the
// frame checksum. Frame: SYNC, LEN0, LEN1, 4*N data bytes, CSUM.
module uart_boot_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    uart_boot_loader_if.master bus,
    output logic               boot_done,
    output logic               boot_error,
    output logic [2:0]         dbg_state
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN0  = 3'd1,
        LEN1  = 3'd2,
        DATA  = 3'd3,
        WRITE = 3'd4,
        CSUM  = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        uart_re_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [7:0]  sum_q;
    logic [7:0]  len_lo_q;
    logic [15:0] count_q;
    logic [1:0]  idx_q;
    logic [23:0] timer_q;
    logic        done_q;
    logic        error_q;

    logic        byte_avail;
    logic        uart_idle;
    logic        accept;
    logic        waiting;
    logic        timeout_hit;
    logic        write_req;
    logic        write_done;
    logic [7:0]  rx_byte;
    logic [7:0]  sum_next;
    logic [15:0] len_word;

    // Decode the UART word and derive accept, write and timeout conditions.
    // The write request waits for uart_re to fall so a memory write never
    // overlaps an open UART read.
    always_comb begin
        rx_byte     = bus.uart_si[7:0];
        byte_avail  = (bus.uart_si[31:8] == 24'h0);
        uart_idle   = (bus.uart_si == 32'hFFFF_FFFF);
        accept      = byte_avail && !uart_re_q &&
                      (state inside {IDLE, LEN0, LEN1, DATA, CSUM});
        sum_next    = sum_q + rx_byte;
        len_word    = {rx_byte, len_lo_q};
        waiting     = (state inside {LEN0, LEN1, DATA, CSUM});
        timeout_hit = waiting && !accept && ((timer_q + 24'd1) == TIMEOUT_CYCLES);
        write_req   = (state == WRITE) && !uart_re_q;
        write_done  = write_req && bus.mem_ready;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; an inter-byte timeout overrides every waiting state.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept && rx_byte == SYNC_BYTE) state_next = LEN0;
            LEN0:  if (accept) state_next = LEN1;
            LEN1:  if (accept) state_next = (len_word == 16'h0) ? CSUM : DATA;
            DATA:  if (accept && idx_q == 2'd3) state_next = WRITE;
            WRITE: if (write_done) state_next = (count_q == 16'd1) ? CSUM : DATA;
            CSUM:  if (accept) state_next = (sum_next == 8'h00) ? DONE : IDLE;
            DONE:  state_next = DONE;
            default: state_next = IDLE;
        endcase
        if (timeout_hit) begin
            state_next = IDLE;
        end
    end

    // Datapath: read strobe, word assembly, address/count, checksum, status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uart_re_q <= 1'b0;
            addr_q    <= BASE_ADDR;
            wdata_q   <= 32'h0;
            sum_q     <= 8'h0;
            len_lo_q  <= 8'h0;
            count_q   <= 16'h0;
            idx_q     <= 2'd0;
            timer_q   <= 24'h0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            if (accept) begin
                uart_re_q <= 1'b1;
            end else if (uart_re_q && uart_idle) begin
                uart_re_q <= 1'b0;
            end

            if (accept || !waiting || timeout_hit) begin
                timer_q <= 24'h0;
            end else begin
                timer_q <= timer_q + 24'd1;
            end

            if (accept) begin
                case (state)
                    IDLE: begin
                        if (rx_byte == SYNC_BYTE) begin
                            error_q <= 1'b0;
                            sum_q   <= 8'h0;
                            addr_q  <= BASE_ADDR;
                            idx_q   <= 2'd0;
                        end
                    end
                    LEN0: begin
                        len_lo_q <= rx_byte;
                        sum_q    <= sum_next;
                    end
                    LEN1: begin
                        count_q <= len_word;
                        sum_q   <= sum_next;
                        idx_q   <= 2'd0;
                    end
                    DATA: begin
                        wdata_q[{idx_q, 3'b000} +: 8] <= rx_byte;
                        sum_q <= sum_next;
                        idx_q <= idx_q + 2'd1;
                    end
                    CSUM: begin
                        sum_q <= sum_next;
                        if (sum_next == 8'h00) begin
                            done_q <= 1'b1;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end

            if (write_done) begin
                addr_q  <= addr_q + 32'd4;
                count_q <= count_q - 16'd1;
            end

            if (timeout_hit) begin
                error_q <= 1'b1;
            end
        end
    end

    assign bus.uart_re   = uart_re_q;
    assign bus.mem_we    = write_req;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign boot_done     = done_q;
    assign boot_error    = error_q;
    assign dbg_state     = state;
endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: a UART byte driver, a memory
// responder with programmable stall, and a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_boot_loader;
    localparam logic [31:0] BASE = 32'hFFFF_FFF8;
    localparam logic [23:0] TOUT = 24'd100;
    localparam logic [7:0]  SYNC = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       boot_done;
    logic       boot_error;
    logic [2:0] dbg_state;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_accept_cyc = 0;
    int stall_min = 0;
    int stall_max = 3;
    bit mon_en = 1'b0;
    int stab_viol = 0;
    int overlap = 0;

    logic [31:0] got_addr_q[$];
    logic [31:0] got_data_q[$];
    int          got_hi_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [7:0]  stream_q[$];
    bit          exp_done = 1'b0;
    bit          exp_err = 1'b0;

    uart_boot_loader_if ifc();

    uart_boot_loader #(
        .BASE_ADDR(BASE),
        .TIMEOUT_CYCLES(TOUT),
        .SYNC_BYTE(SYNC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc),
        .boot_done(boot_done),
        .boot_error(boot_error),
        .dbg_state(dbg_state)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: stalls each write, records transfers, and counts
    // payload instability and UART-read overlap.
    initial begin : mem_responder
        logic        we_s;
        logic [31:0] a_s;
        logic [31:0] d_s;
        int          hi;
        int          target;
        bit          pending;
        ifc.mem_ready = 1'b0;
        we_s = 1'b0; a_s = 32'h0; d_s = 32'h0; hi = 0; target = 0; pending = 1'b0;
        forever begin
            @(posedge clk);
            pending = 1'b0;
            if (!rst && we_s) begin
                if (ifc.mem_ready) begin
                    got_addr_q.push_back(a_s);
                    got_data_q.push_back(d_s);
                    got_hi_q.push_back(hi);
                    hi = 0;
                end else begin
                    pending = 1'b1;
                end
            end
            #1;
            if (rst) begin
                ifc.mem_ready = 1'b0;
                we_s = 1'b0;
                hi = 0;
            end else begin
                if (mon_en && pending && (ifc.mem_we !== 1'b1 || ifc.mem_addr !== a_s ||
                                          ifc.mem_wdata !== d_s)) stab_viol++;
                if (ifc.mem_we === 1'b1 && ifc.uart_re === 1'b1) overlap++;
                we_s = (ifc.mem_we === 1'b1);
                a_s = ifc.mem_addr;
                d_s = ifc.mem_wdata;
                if (we_s) begin
                    if (hi == 0) target = int'($urandom_range(stall_max, stall_min));
                    hi++;
                    ifc.mem_ready = (hi > target);
                end else begin
                    ifc.mem_ready = 1'b0;
                end
            end
        end
    end

    // Global time limit.
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic do_reset();
        mon_en = 1'b0;
        ifc.uart_si = 32'hFFFF_FFFF;
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        got_addr_q.delete(); got_data_q.delete(); got_hi_q.delete();
        exp_addr_q.delete(); exp_data_q.delete(); stream_q.delete();
        exp_done = 1'b0;
        exp_err = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        mon_en = 1'b1;
    endtask

    // Presents one byte; if it must be accepted, waits for uart_re and then
    // clears the UART word after a random delay.
    task automatic send_byte(input logic [7:0] b, input bit expect_accept);
        int t;
        repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
        t = 0;
        while (ifc.uart_re !== 1'b0 && t < 50) begin @(posedge clk); #1; t++; end
        checks++;
        if (ifc.uart_re !== 1'b0) begin
            errors++;
            $display("FAIL uart_re_release: uart_re=%b, required 0 within 50 cycles", ifc.uart_re);
        end
        ifc.uart_si = {24'h0, b};
        if (expect_accept) begin
            t = 0;
            while (ifc.uart_re !== 1'b1 && t < 300) begin @(posedge clk); #1; t++; end
            checks++;
            if (ifc.uart_re !== 1'b1) begin
                errors++;
                $display("FAIL uart_accept byte=%02h: uart_re=%b, required 1 within 300 cycles", b, ifc.uart_re);
            end
            last_accept_cyc = cyc;
            repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
        end else begin
            t = 0;
            repeat (20) begin @(posedge clk); #1; if (ifc.uart_re !== 1'b0) t++; end
            checks++;
            if (t != 0) begin
                errors++;
                $display("FAIL ignored_byte %02h: uart_re high for %0d cycles, required 0", b, t);
            end
        end
        ifc.uart_si = 32'hFFFF_FFFF;
    endtask

    // Appends a frame with N random words; bad adds one to the checksum.
    task automatic build_frame(input int n, input bit bad);
        int         total;
        logic [7:0] b;
        stream_q.push_back(SYNC);
        stream_q.push_back(8'(n));
        stream_q.push_back(8'(n >> 8));
        total = (n & 255) + ((n >> 8) & 255);
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom_range(255, 0));
            if (i == 0 && $urandom_range(1, 0) == 1) b = SYNC;
            stream_q.push_back(b);
            total += int'(b);
        end
        b = 8'((256 - (total % 256)) % 256);
        if (bad) b = b + 8'd1;
        stream_q.push_back(b);
    endtask

    // Reference model: walks the byte stream frame by frame and produces the
    // expected writes and final status.
    task automatic model_stream();
        int          i;
        int          n;
        int          total;
        logic [31:0] w;
        i = 0;
        while (i < stream_q.size() && !exp_done) begin
            if (stream_q[i] != SYNC) begin
                i++;
            end else begin
                exp_err = 1'b0;
                i++;
                n = int'(stream_q[i]) + 256 * int'(stream_q[i + 1]);
                total = int'(stream_q[i]) + int'(stream_q[i + 1]);
                i += 2;
                for (int k = 0; k < n; k++) begin
                    w = 32'h0;
                    for (int bi = 0; bi < 4; bi++) begin
                        w[8 * bi +: 8] = stream_q[i];
                        total += int'(stream_q[i]);
                        i++;
                    end
                    exp_addr_q.push_back(BASE + 32'(4 * k));
                    exp_data_q.push_back(w);
                end
                total += int'(stream_q[i]);
                i++;
                if (total % 256 == 0) exp_done = 1'b1;
                else exp_err = 1'b1;
            end
        end
    endtask

    task automatic run_stream();
        for (int i = 0; i < stream_q.size(); i++) send_byte(stream_q[i], 1'b1);
        model_stream();
        stream_q.delete();
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ifc.uart_re !== 1'b0) begin errors++; $display("FAIL reset_uart_re: got %b, required 0", ifc.uart_re); end
        checks++; if (ifc.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b, required 0", ifc.mem_we); end
        checks++; if (ifc.mem_addr !== BASE) begin errors++; $display("FAIL reset_mem_addr: got %08h, required %08h", ifc.mem_addr, BASE); end
        checks++; if (ifc.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %08h, required 0", ifc.mem_wdata); end
        checks++; if (boot_done !== 1'b0) begin errors++; $display("FAIL reset_boot_done: got %b, required 0", boot_done); end
        checks++; if (boot_error !== 1'b0) begin errors++; $display("FAIL reset_boot_error: got %b, required 0", boot_error); end
        checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d, required 0 (IDLE)", dbg_state); end
    endtask

    task automatic test_good_frame();
        do_reset();
        stream_q = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hC7};
        run_stream();
        checks++; if (got_addr_q.size() != 1) begin errors++; $display("FAIL good_write_count: got %0d, required 1", got_addr_q.size()); end
        for (int i = 0; i < exp_addr_q.size(); i++) begin
            checks++;
            if (i >= got_addr_q.size() || got_addr_q[i] !== exp_addr_q[i] || got_data_q[i] !== exp_data_q[i]) begin
                errors++;
                $display("FAIL good_write[%0d]: got %0d writes, required addr=%08h data=%08h", i, got_addr_q.size(), exp_addr_q[i], exp_data_q[i]);
            end
        end
        checks++; if (boot_done !== exp_done) begin errors++; $display("FAIL good_boot_done: got %b, required %b", boot_done, exp_done); end
        checks++; if (boot_error !== exp_err) begin errors++; $display("FAIL good_boot_error: got %b, required %b", boot_error, exp_err); end
        send_byte(SYNC, 1'b0);
        checks++; if (got_addr_q.size() != 1 || boot_done !== 1'b1) begin errors++; $display("FAIL done_ignores_bytes: writes=%0d done=%b, required 1 and 1", got_addr_q.size(), boot_done); end
    endtask

    task automatic test_bad_then_good();
        do_reset();
        stream_q = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hC8};
        run_stream();
        checks++;
        if (got_addr_q.size() != 1 || got_addr_q[0] !== BASE || got_data_q[0] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL bad_write: got %0d writes, required one to %08h of deadbeef", got_addr_q.size(), BASE);
        end
        checks++; if (boot_error !== exp_err) begin errors++; $display("FAIL bad_boot_error: got %b, required %b", boot_error, exp_err); end
        checks++; if (boot_done !== exp_done) begin errors++; $display("FAIL bad_boot_done: got %b, required %b", boot_done, exp_done); end
        checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL bad_state: got %0d, required 0 (IDLE)", dbg_state); end
        got_addr_q.delete(); got_data_q.delete(); got_hi_q.delete();
        exp_addr_q.delete(); exp_data_q.delete();
        build_frame(3, 1'b0);
        run_stream();
        checks++; if (got_addr_q.size() != exp_addr_q.size()) begin errors++; $display("FAIL regood_write_count: got %0d, required %0d", got_addr_q.size(), exp_addr_q.size()); end
        for (int i = 0; i < exp_addr_q.size(); i++) begin
            checks++;
            if (i >= got_addr_q.size() || got_addr_q[i] !== exp_addr_q[i] || got_data_q[i] !== exp_data_q[i]) begin
                errors++;
                $display("FAIL regood_write[%0d]: got %0d writes, required addr=%08h data=%08h", i, got_addr_q.size(), exp_addr_q[i], exp_data_q[i]);
            end
        end
        checks++; if (boot_done !== exp_done || boot_error !== exp_err) begin errors++; $display("FAIL regood_status: got done=%b err=%b, required done=%b err=%b", boot_done, boot_error, exp_done, exp_err); end
    endtask

    task automatic test_n0_discard();
        do_reset();
        stream_q = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
        run_stream();
        checks++; if (got_addr_q.size() != exp_addr_q.size()) begin errors++; $display("FAIL n0_write_count: got %0d, required %0d", got_addr_q.size(), exp_addr_q.size()); end
        checks++; if (boot_done !== exp_done || boot_error !== exp_err) begin errors++; $display("FAIL n0_status: got done=%b err=%b, required done=%b err=%b", boot_done, boot_error, exp_done, exp_err); end
    endtask

    task automatic test_stall();
        do_reset();
        stall_min = 10; stall_max = 10;
        stab_viol = 0; overlap = 0;
        build_frame(2, 1'b0);
        run_stream();
        checks++; if (got_addr_q.size() != 2) begin errors++; $display("FAIL stall_write_count: got %0d, required 2", got_addr_q.size()); end
        for (int i = 0; i < exp_addr_q.size(); i++) begin
            checks++;
            if (i >= got_addr_q.size() || got_addr_q[i] !== exp_addr_q[i] || got_data_q[i] !== exp_data_q[i] || got_hi_q[i] != 11) begin
                errors++;
                $display("FAIL stall_write[%0d]: got %0d writes, required addr=%08h data=%08h held 11 cycles", i, got_addr_q.size(), exp_addr_q[i], exp_data_q[i]);
            end
        end
        checks++; if (stab_viol != 0) begin errors++; $display("FAIL stall_stability: got %0d unstable cycles, required 0", stab_viol); end
        checks++; if (overlap != 0) begin errors++; $display("FAIL stall_re_overlap: got %0d cycles, required 0", overlap); end
        checks++; if (boot_done !== exp_done) begin errors++; $display("FAIL stall_boot_done: got %b, required %b", boot_done, exp_done); end
        stall_min = 0; stall_max = 3;
    endtask

    task automatic test_timeout();
        int t;
        int re_hi;
        do_reset();
        send_byte(SYNC, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        t = 0;
        while (boot_error !== 1'b1 && t < 300) begin @(posedge clk); #1; t++; end
        checks++; if (boot_error !== 1'b1 || (cyc - last_accept_cyc) != 100) begin errors++; $display("FAIL timeout_latency: error=%b after %0d cycles, required 1 after 100", boot_error, cyc - last_accept_cyc); end
        checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL timeout_state: got %0d, required 0 (IDLE)", dbg_state); end
        re_hi = 0;
        repeat (20) begin if (ifc.uart_re !== 1'b0) re_hi++; @(posedge clk); #1; end
        checks++; if (re_hi != 0) begin errors++; $display("FAIL timeout_uart_re: high for %0d cycles, required 0", re_hi); end
        checks++; if (got_addr_q.size() != 0 || boot_done !== 1'b0) begin errors++; $display("FAIL timeout_side_effects: writes=%0d done=%b, required 0 and 0", got_addr_q.size(), boot_done); end
        build_frame(1, 1'b0);
        run_stream();
        checks++; if (boot_done !== exp_done || boot_error !== exp_err || got_addr_q.size() != exp_addr_q.size()) begin
            errors++; $display("FAIL timeout_recover: done=%b err=%b writes=%0d, required %b %b %0d", boot_done, boot_error, got_addr_q.size(), exp_done, exp_err, exp_addr_q.size());
        end
    endtask

    task automatic test_random();
        logic [7:0] junk;
        int         n;
        bit         bad;
        stab_viol = 0; overlap = 0;
        for (int it = 0; it < 6; it++) begin
            do_reset();
            junk = 8'($urandom_range(255, 0));
            if (junk != SYNC && $urandom_range(1, 0) == 1) stream_q.push_back(junk);
            n = int'($urandom_range(4, 0));
            bad = ($urandom_range(1, 0) == 1);
            build_frame(n, bad);
            run_stream();
            checks++; if (got_addr_q.size() != exp_addr_q.size()) begin errors++; $display("FAIL rand%0d_write_count: got %0d, required %0d", it, got_addr_q.size(), exp_addr_q.size()); end
            for (int i = 0; i < exp_addr_q.size(); i++) begin
                checks++;
                if (i >= got_addr_q.size() || got_addr_q[i] !== exp_addr_q[i] || got_data_q[i] !== exp_data_q[i]) begin
                    errors++;
                    $display("FAIL rand%0d_write[%0d]: got %0d writes, required addr=%08h data=%08h", it, i, got_addr_q.size(), exp_addr_q[i], exp_data_q[i]);
                end
            end
            checks++; if (boot_done !== exp_done || boot_error !== exp_err) begin errors++; $display("FAIL rand%0d_status: got done=%b err=%b, required done=%b err=%b", it, boot_done, boot_error, exp_done, exp_err); end
        end
        checks++; if (stab_viol != 0 || overlap != 0) begin errors++; $display("FAIL rand_bus_rules: unstable=%0d overlap=%0d, required 0 and 0", stab_viol, overlap); end
    endtask

    task automatic test_reset_mid_write();
        int t;
        do_reset();
        stall_min = 1000; stall_max = 1000;
        send_byte(SYNC, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(255, 0)), 1'b1);
        t = 0;
        while (ifc.mem_we !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        checks++; if (ifc.mem_we !== 1'b1) begin errors++; $display("FAIL midwrite_we: got %b, required 1 before reset", ifc.mem_we); end
        mon_en = 1'b0;
        #3 rst = 1'b1;
        #1;
        checks++; if (ifc.mem_we !== 1'b0 || ifc.uart_re !== 1'b0) begin errors++; $display("FAIL async_reset_strobes: we=%b re=%b, required 0 0", ifc.mem_we, ifc.uart_re); end
        checks++; if (ifc.mem_addr !== BASE || ifc.mem_wdata !== 32'h0) begin errors++; $display("FAIL async_reset_bus: addr=%08h data=%08h, required %08h 0", ifc.mem_addr, ifc.mem_wdata, BASE); end
        checks++; if (boot_done !== 1'b0 || boot_error !== 1'b0 || dbg_state !== 3'd0) begin errors++; $display("FAIL async_reset_status: done=%b err=%b state=%0d, required 0 0 0", boot_done, boot_error, dbg_state); end
        @(posedge clk); #1;
        stall_min = 0; stall_max = 3;
        do_reset();
        checks++; if (got_addr_q.size() != 0) begin errors++; $display("FAIL midwrite_no_commit: got %0d writes, required 0", got_addr_q.size()); end
    endtask

    initial begin
        ifc.uart_si = 32'hFFFF_FFFF;
        test_reset();
        test_good_frame();
        test_bad_then_good();
        test_n0_discard();
        test_stall();
        test_timeout();
        test_random();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
